// File: rtl/bist_pkg.sv
// Shared types and default widths for the BIST response checker.
// The optional failure log is enabled by defining BIST_FAIL_LOG_EN.
package bist_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CHECK = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } bist_state_e;

  localparam int DEF_ADDR_W    = 5;
  localparam int DEF_DATA_W    = 8;
  localparam int DEF_ERR_CNT_W = 8;
  localparam int DEF_RD_LAT    = 1;
  // Drain counter holds RD_LAT-1, RD_LAT being at most 4.
  localparam int DRAIN_CNT_W   = 3;
  localparam int LOG_DEPTH     = 4;

endpackage

// File: rtl/bist_resp_chk_if.sv
// Bus between a BIST controller/SRAM and the response checker.
// Log signals exist only when BIST_FAIL_LOG_EN is defined.
interface bist_resp_chk_if
  import bist_pkg::*;
#(
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter int DATA_W    = DEF_DATA_W,
  parameter int ERR_CNT_W = DEF_ERR_CNT_W
) ();

  logic                 start;
  logic                 rd_en;
  logic [ADDR_W-1:0]    rd_addr;
  logic [DATA_W-1:0]    exp_data;
  logic                 last;
  logic [DATA_W-1:0]    rd_data;
  logic                 busy;
  logic                 done;
  logic                 fail;
  logic [ERR_CNT_W-1:0] err_cnt;
  logic [ADDR_W-1:0]    first_fail_addr;
  logic [DATA_W-1:0]    first_fail_mask;
`ifdef BIST_FAIL_LOG_EN
  logic [1:0]           log_idx;
  logic [ADDR_W-1:0]    log_addr;
  logic [2:0]           log_cnt;
`endif

  modport master (
    output start, rd_en, rd_addr, exp_data, last, rd_data,
`ifdef BIST_FAIL_LOG_EN
    output log_idx,
    input  log_addr, log_cnt,
`endif
    input  busy, done, fail, err_cnt, first_fail_addr, first_fail_mask
  );

  modport slave (
    input  start, rd_en, rd_addr, exp_data, last, rd_data,
`ifdef BIST_FAIL_LOG_EN
    input  log_idx,
    output log_addr, log_cnt,
`endif
    output busy, done, fail, err_cnt, first_fail_addr, first_fail_mask
  );

endinterface

// File: rtl/bist_delay_line.sv
// Register pipe that carries read valid, address and expected data
// DEPTH cycles so they line up with the SRAM read data.
module bist_delay_line #(
  parameter int DEPTH = 1,
  parameter int AW    = 5,
  parameter int DW    = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr,
  input  logic          in_valid,
  input  logic [AW-1:0] in_addr,
  input  logic [DW-1:0] in_data,
  output logic          out_valid,
  output logic [AW-1:0] out_addr,
  output logic [DW-1:0] out_data
);

  logic [DEPTH-1:0]         vld_q, vld_d;
  logic [DEPTH-1:0][AW-1:0] addr_q, addr_d;
  logic [DEPTH-1:0][DW-1:0] data_q, data_d;

  // Shift the pipe by one stage, or empty it on clear.
  always_comb begin
    vld_d  = vld_q;
    addr_d = addr_q;
    data_d = data_q;
    if (clr) begin
      vld_d  = '0;
      addr_d = '0;
      data_d = '0;
    end else begin
      vld_d[0]  = in_valid;
      addr_d[0] = in_addr;
      data_d[0] = in_data;
      for (int i = 1; i < DEPTH; i++) begin
        vld_d[i]  = vld_q[i-1];
        addr_d[i] = addr_q[i-1];
        data_d[i] = data_q[i-1];
      end
    end
  end

  // Pipe registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q  <= '0;
      addr_q <= '0;
      data_q <= '0;
    end else begin
      vld_q  <= vld_d;
      addr_q <= addr_d;
      data_q <= data_d;
    end
  end

  assign out_valid = vld_q[DEPTH-1];
  assign out_addr  = addr_q[DEPTH-1];
  assign out_data  = data_q[DEPTH-1];

endmodule

// File: rtl/bist_resp_chk.sv
// BIST response checker: compares SRAM read data against expected data
// RD_LAT cycles after each read and accumulates pass/fail results.
// Define BIST_FAIL_LOG_EN to add a 4-entry log of failing addresses.
module bist_resp_chk
  import bist_pkg::*;
#(
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter int DATA_W    = DEF_DATA_W,
  parameter int ERR_CNT_W = DEF_ERR_CNT_W,
  parameter int RD_LAT    = DEF_RD_LAT
) (
  input logic            clk,
  input logic            rst_n,
  bist_resp_chk_if.slave bus
);

  localparam logic [ERR_CNT_W-1:0] ERR_MAX = '1;

  bist_state_e            state_q, state_d;
  logic [DRAIN_CNT_W-1:0] drain_cnt_q, drain_cnt_d;
  logic                   busy_q, busy_d, done_q, done_d, fail_q, fail_d;
  logic [ERR_CNT_W-1:0]   err_cnt_q, err_cnt_d;
  logic [ADDR_W-1:0]      ffa_q, ffa_d;
  logic [DATA_W-1:0]      ffm_q, ffm_d;

  logic                   accept_s, dl_valid_s, mismatch_s;
  logic [ADDR_W-1:0]      dl_addr_s;
  logic [DATA_W-1:0]      dl_exp_s, diff_s;

  // Reads count only inside a session; a read beside start belongs to no session.
  assign accept_s   = bus.rd_en & ~bus.start & (state_q == ST_CHECK);
  assign diff_s     = bus.rd_data ^ dl_exp_s;
  assign mismatch_s = dl_valid_s & (diff_s != '0);

  bist_delay_line #(
    .DEPTH (RD_LAT),
    .AW    (ADDR_W),
    .DW    (DATA_W)
  ) u_dly (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (bus.start),
    .in_valid  (accept_s),
    .in_addr   (bus.rd_addr),
    .in_data   (bus.exp_data),
    .out_valid (dl_valid_s),
    .out_addr  (dl_addr_s),
    .out_data  (dl_exp_s)
  );

  // Session sequencing: start restarts from anywhere, last read opens the drain.
  always_comb begin
    state_d     = state_q;
    drain_cnt_d = drain_cnt_q;
    if (bus.start) begin
      state_d     = ST_CHECK;
      drain_cnt_d = '0;
    end else begin
      case (state_q)
        ST_IDLE:  state_d = ST_IDLE;
        ST_CHECK: begin
          if (accept_s && bus.last) begin
            state_d     = ST_DRAIN;
            drain_cnt_d = DRAIN_CNT_W'(RD_LAT - 1);
          end else begin
            state_d = ST_CHECK;
          end
        end
        ST_DRAIN: begin
          if (drain_cnt_q == '0) begin
            state_d = ST_DONE;
          end else begin
            drain_cnt_d = drain_cnt_q - DRAIN_CNT_W'(1);
          end
        end
        ST_DONE:  state_d = ST_DONE;
        default:  state_d = ST_IDLE;
      endcase
    end
  end

  // Result accumulation; start discards whatever is still comparing.
  always_comb begin
    busy_d    = (state_d == ST_CHECK) || (state_d == ST_DRAIN);
    done_d    = (state_d == ST_DONE);
    fail_d    = fail_q;
    err_cnt_d = err_cnt_q;
    ffa_d     = ffa_q;
    ffm_d     = ffm_q;
    if (bus.start) begin
      fail_d    = 1'b0;
      err_cnt_d = '0;
      ffa_d     = '0;
      ffm_d     = '0;
    end else if (mismatch_s) begin
      fail_d = 1'b1;
      if (err_cnt_q != ERR_MAX) begin
        err_cnt_d = err_cnt_q + ERR_CNT_W'(1);
      end else begin
        err_cnt_d = err_cnt_q;
      end
      if (err_cnt_q == '0) begin
        ffa_d = dl_addr_s;
        ffm_d = diff_s;
      end else begin
        ffa_d = ffa_q;
        ffm_d = ffm_q;
      end
    end else begin
      fail_d = fail_q;
    end
  end

  // State and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      drain_cnt_q <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      fail_q      <= 1'b0;
      err_cnt_q   <= '0;
      ffa_q       <= '0;
      ffm_q       <= '0;
    end else begin
      state_q     <= state_d;
      drain_cnt_q <= drain_cnt_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      fail_q      <= fail_d;
      err_cnt_q   <= err_cnt_d;
      ffa_q       <= ffa_d;
      ffm_q       <= ffm_d;
    end
  end

  assign bus.busy            = busy_q;
  assign bus.done            = done_q;
  assign bus.fail            = fail_q;
  assign bus.err_cnt         = err_cnt_q;
  assign bus.first_fail_addr = ffa_q;
  assign bus.first_fail_mask = ffm_q;

`ifdef BIST_FAIL_LOG_EN
  logic [LOG_DEPTH-1:0][ADDR_W-1:0] log_q, log_d;
  logic [2:0]                       log_cnt_q, log_cnt_d;

  // Record the first four failing addresses, ignore the rest.
  always_comb begin
    log_d     = log_q;
    log_cnt_d = log_cnt_q;
    if (bus.start) begin
      log_d     = '0;
      log_cnt_d = 3'd0;
    end else if (mismatch_s && (log_cnt_q < 3'd4)) begin
      log_d[log_cnt_q[1:0]] = dl_addr_s;
      log_cnt_d             = log_cnt_q + 3'd1;
    end else begin
      log_cnt_d = log_cnt_q;
    end
  end

  // Log registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      log_q     <= '0;
      log_cnt_q <= 3'd0;
    end else begin
      log_q     <= log_d;
      log_cnt_q <= log_cnt_d;
    end
  end

  assign bus.log_addr = log_q[bus.log_idx];
  assign bus.log_cnt  = log_cnt_q;
`endif

endmodule

// File: tb/tb_bist_resp_chk.sv
// Self-checking bench for bist_resp_chk. Three instances share stimulus:
// A (defaults), B (ERR_CNT_W=2) and C (RD_LAT=3), each fed by an SRAM model
// with matching latency.
module tb_bist_resp_chk;

  typedef struct packed {
    logic       fail;
    logic [7:0] cnt;
    logic [1:0] cnt_b;
    logic [4:0] ffa;
    logic [7:0] ffm;
  } exp_t;

  typedef struct packed {
    logic [31:0] fmap;
    logic [7:0]  flip;
    exp_t        e;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst_n, start, rd_en, last;
  logic [4:0] rd_addr;
  logic [7:0] exp_data;
  logic [7:0] mem [32];
  logic [7:0] p1, p2, p3;
  int         cyc = 0;
  int         n_chk = 0;
  int         n_fail = 0;
  exp_t       sb_q [$];
  vec_t       vecs [6];

  bist_resp_chk_if                   if_a ();
  bist_resp_chk_if #(.ERR_CNT_W(2))  if_b ();
  bist_resp_chk_if                   if_c ();

  assign if_a.start = start;  assign if_b.start = start;  assign if_c.start = start;
  assign if_a.rd_en = rd_en;  assign if_b.rd_en = rd_en;  assign if_c.rd_en = rd_en;
  assign if_a.last  = last;   assign if_b.last  = last;   assign if_c.last  = last;
  assign if_a.rd_addr  = rd_addr;  assign if_b.rd_addr  = rd_addr;  assign if_c.rd_addr  = rd_addr;
  assign if_a.exp_data = exp_data; assign if_b.exp_data = exp_data; assign if_c.exp_data = exp_data;
  assign if_a.rd_data = p1;
  assign if_b.rd_data = p1;
  assign if_c.rd_data = p3;
`ifdef BIST_FAIL_LOG_EN
  assign if_a.log_idx = 2'd0;
  assign if_b.log_idx = 2'd0;
  assign if_c.log_idx = 2'd0;
`endif

  bist_resp_chk u_a (.clk(clk), .rst_n(rst_n), .bus(if_a));
  bist_resp_chk #(.ERR_CNT_W(2)) u_b (.clk(clk), .rst_n(rst_n), .bus(if_b));
  bist_resp_chk #(.RD_LAT(3)) u_c (.clk(clk), .rst_n(rst_n), .bus(if_c));

  always #5 clk = ~clk;

  // SRAM model: read data appears 1 (p1) or 3 (p3) cycles after the read.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    p1  <= mem[rd_addr];
    p2  <= p1;
    p3  <= p2;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    n_chk++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp_v, $time);
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Called at the negedge right after the last read was sampled.
  task automatic finish_session(input int l_cyc);
    int   da, dc;
    exp_t e;
    da = -1;
    dc = -1;
    rd_en = 1'b0;
    last  = 1'b0;
    chk("drain_busy", if_a.busy, 32'd1);
    chk("drain_not_done", if_a.done, 32'd0);
    for (int k = 0; k < 12; k++) begin
      if (da < 0 && if_a.done === 1'b1) da = cyc - l_cyc;
      if (dc < 0 && if_c.done === 1'b1) dc = cyc - l_cyc;
      @(negedge clk);
    end
    chk("done_lat_a", da, 32'd2);
    chk("done_lat_c", dc, 32'd4);
    chk("done_hold", if_a.done, 32'd1);
    chk("busy_in_done", if_a.busy, 32'd0);
    if (sb_q.size() == 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL scoreboard_empty: got no entry, expected one");
    end else begin
      e = sb_q.pop_front();
      chk("fail_a", if_a.fail, 32'(e.fail));
      chk("err_cnt_a", if_a.err_cnt, 32'(e.cnt));
      chk("ffa_a", if_a.first_fail_addr, 32'(e.ffa));
      chk("ffm_a", if_a.first_fail_mask, 32'(e.ffm));
      chk("err_cnt_b", if_b.err_cnt, 32'(e.cnt_b));
      chk("err_cnt_c", if_c.err_cnt, 32'(e.cnt));
      chk("ffa_c", if_c.first_fail_addr, 32'(e.ffa));
    end
  endtask

  task automatic run_session(input vec_t v);
    int l_cyc;
    l_cyc = 0;
    for (int i = 0; i < 32; i++) mem[i] = v.fmap[i] ? (8'hA5 ^ v.flip) : 8'hA5;
    pulse_start();
    chk("busy_after_start", if_a.busy, 32'd1);
    for (int i = 0; i < 32; i++) begin
      rd_en    = 1'b1;
      rd_addr  = 5'(i);
      exp_data = 8'hA5;
      last     = (i == 31);
      if (i == 31) begin
        l_cyc = cyc;
        sb_q.push_back(v.e);
      end
      @(negedge clk);
    end
    finish_session(l_cyc);
  endtask

  initial begin
    int   l_cyc;
    int   seq [5];
    exp_t e0;

    vecs[0] = '{32'h0000_0000, 8'h00, '{1'b0, 8'd0,  2'd0, 5'd0,  8'h00}};
    vecs[1] = '{32'h0000_0080, 8'h01, '{1'b1, 8'd1,  2'd1, 5'd7,  8'h01}};
    vecs[2] = '{32'h0000_0208, 8'h10, '{1'b1, 8'd2,  2'd2, 5'd3,  8'h10}};
    vecs[3] = '{32'h0001_0116, 8'h0F, '{1'b1, 8'd5,  2'd3, 5'd1,  8'h0F}};
    vecs[4] = '{32'h8000_0000, 8'hFF, '{1'b1, 8'd1,  2'd1, 5'd31, 8'hFF}};
    vecs[5] = '{32'hFFFF_FFFF, 8'h5A, '{1'b1, 8'd32, 2'd3, 5'd0,  8'h5A}};
    e0      = '{1'b0, 8'd0, 2'd0, 5'd0, 8'h00};

    rst_n = 1'b0; start = 1'b0; rd_en = 1'b0; last = 1'b0;
    rd_addr = 5'd0; exp_data = 8'h00;
    for (int i = 0; i < 32; i++) mem[i] = 8'hA5;
    repeat (3) @(negedge clk);
    chk("rst_busy", if_a.busy, 32'd0);
    chk("rst_done", if_a.done, 32'd0);
    chk("rst_fail", if_a.fail, 32'd0);
    chk("rst_err_cnt", if_a.err_cnt, 32'd0);
    chk("rst_ffa", if_a.first_fail_addr, 32'd0);
    chk("rst_ffm", if_a.first_fail_mask, 32'd0);
    rst_n = 1'b1;

    // Reads in IDLE must be ignored.
    mem[0] = 8'h00;
    rd_en = 1'b1; rd_addr = 5'd0; exp_data = 8'hA5; last = 1'b1;
    repeat (3) @(negedge clk);
    rd_en = 1'b0; last = 1'b0;
    repeat (3) @(negedge clk);
    chk("idle_busy", if_a.busy, 32'd0);
    chk("idle_fail", if_a.fail, 32'd0);
    chk("idle_err_cnt", if_a.err_cnt, 32'd0);
    chk("idle_done", if_a.done, 32'd0);

    // Table-driven sessions.
    for (int v = 0; v < 6; v++) run_session(vecs[v]);

    // Restart mid-CHECK after one fault; in-flight and coincident reads dropped.
    for (int i = 0; i < 32; i++) mem[i] = 8'hA5;
    mem[2] = 8'hA4;
    seq = '{0, 1, 2, 3, 2};
    pulse_start();
    for (int i = 0; i < 5; i++) begin
      rd_en = 1'b1; rd_addr = 5'(seq[i]); exp_data = 8'hA5; last = 1'b0;
      if (i == 4) begin
        chk("restart_pre_fail", if_a.fail, 32'd1);
        chk("restart_pre_cnt", if_a.err_cnt, 32'd1);
      end
      @(negedge clk);
    end
    start = 1'b1; rd_en = 1'b1; rd_addr = 5'd2;
    @(negedge clk);
    start = 1'b0;
    chk("restart_fail_clr", if_a.fail, 32'd0);
    chk("restart_cnt_clr", if_a.err_cnt, 32'd0);
    chk("restart_ffa_clr", if_a.first_fail_addr, 32'd0);
    chk("restart_ffm_clr", if_a.first_fail_mask, 32'd0);
    chk("restart_busy", if_a.busy, 32'd1);
    l_cyc = 0;
    for (int i = 0; i < 32; i++) begin
      if (i != 2) begin
        rd_en = 1'b1; rd_addr = 5'(i); exp_data = 8'hA5; last = (i == 31);
        if (i == 31) begin
          l_cyc = cyc;
          sb_q.push_back(e0);
        end
        @(negedge clk);
      end
    end
    finish_session(l_cyc);

    // Reads during DONE are ignored.
    rd_en = 1'b1; rd_addr = 5'd2; exp_data = 8'hA5; last = 1'b1;
    repeat (4) @(negedge clk);
    rd_en = 1'b0; last = 1'b0;
    repeat (3) @(negedge clk);
    chk("doneread_done", if_a.done, 32'd1);
    chk("doneread_cnt", if_a.err_cnt, 32'd0);
    chk("doneread_fail", if_a.fail, 32'd0);
    chk("doneread_busy", if_a.busy, 32'd0);

    // Asynchronous reset while draining.
    for (int i = 0; i < 32; i++) mem[i] = 8'hA5;
    mem[0] = 8'h00;
    pulse_start();
    l_cyc = 0;
    for (int i = 0; i < 32; i++) begin
      rd_en = 1'b1; rd_addr = 5'(i); exp_data = 8'hA5; last = (i == 31);
      if (i == 31) l_cyc = cyc;
      @(negedge clk);
    end
    rd_en = 1'b0; last = 1'b0;
    chk("arst_pre_fail", if_a.fail, 32'd1);
    chk("arst_pre_busy_c", if_c.busy, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_busy", if_a.busy, 32'd0);
    chk("arst_done", if_a.done, 32'd0);
    chk("arst_fail", if_a.fail, 32'd0);
    chk("arst_err_cnt", if_a.err_cnt, 32'd0);
    chk("arst_ffa", if_a.first_fail_addr, 32'd0);
    chk("arst_ffm", if_a.first_fail_mask, 32'd0);
    chk("arst_busy_c", if_c.busy, 32'd0);
    chk("arst_fail_c", if_c.fail, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    chk("arst_idle_done", if_a.done, 32'd0);
    chk("arst_idle_busy", if_a.busy, 32'd0);
    chk("arst_idle_done_c", if_c.done, 32'd0);
    chk("arst_idle_busy_c", if_c.busy, 32'd0);
    chk("arst_tag", l_cyc > 0 ? 32'd1 : 32'd0, 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  // Global time bound in case a wait ever stalls.
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/bist_resp_chk.md
BIST_RESP_CHK -- requirements
Module: bist_resp_chk

Interface
REQ-001 SHALL have parameter ADDR_W, default 5, SRAM address width.
REQ-002 SHALL have parameter DATA_W, default 8, SRAM data width.
REQ-003 SHALL have parameter ERR_CNT_W, default 8, error counter width.
REQ-004 SHALL have parameter RD_LAT, default 1 (legal 1..4), cycles from read issue to valid rd_data.
REQ-005 SHALL use one clock; reset is asynchronous and active-low.
REQ-006 SHALL have port clk  input  1  rising-edge clock.
REQ-007 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-008 SHALL have port start  input  1  one-cycle pulse that opens a check session and clears results.
REQ-009 SHALL have port rd_en  input  1  BIST controller issued an SRAM read this cycle.
REQ-010 SHALL have port rd_addr  input  ADDR_W  read address, qualified by rd_en.
REQ-011 SHALL have port exp_data  input  DATA_W  expected data, qualified by rd_en.
REQ-012 SHALL have port last  input  1  marks the final read of the session, qualified by rd_en.
REQ-013 SHALL have port rd_data  input  DATA_W  SRAM read data, valid RD_LAT cycles after rd_en.
REQ-014 SHALL have port busy  output  1  high in CHECK or DRAIN.
REQ-015 SHALL have port done  output  1  high in DONE.
REQ-016 SHALL have port fail  output  1  sticky: at least one mismatch this session.
REQ-017 SHALL have port err_cnt  output  ERR_CNT_W  count of mismatching reads.
REQ-018 SHALL have port first_fail_addr  output  ADDR_W  address of the first mismatch.
REQ-019 SHALL have port first_fail_mask  output  DATA_W  rd_data XOR exp_data of the first mismatch.

Function
REQ-020 SHALL implement states IDLE, CHECK, DRAIN and DONE.
REQ-021 SHALL, on start in any state, clear fail, err_cnt, first_fail_addr, first_fail_mask and the pipeline, then enter CHECK next cycle.
REQ-022 SHALL accept rd_en only in CHECK; rd_en in IDLE, DRAIN, DONE or coincident with start is ignored.
REQ-023 SHALL delay valid, rd_addr and exp_data by RD_LAT stages so each aligns with its rd_data.
REQ-024 SHALL flag a mismatch when an aligned valid stage has rd_data differing from exp_data in any bit.
REQ-025 SHALL, on mismatch, set fail and increment err_cnt, saturating at 2^ERR_CNT_W-1 with no wrap.
REQ-026 SHALL capture first_fail_addr and first_fail_mask only on the mismatch that finds err_cnt at 0.
REQ-027 SHALL make the result of a read issued in cycle t visible on outputs in cycle t+RD_LAT+1.
REQ-028 SHALL go from CHECK to DRAIN on accepted rd_en with last, stay in DRAIN RD_LAT cycles, then enter DONE.
REQ-029 SHALL assert done in cycle t+RD_LAT+1 for a last read in cycle t, with final results valid that cycle.
REQ-030 SHALL hold DONE and all results until start or reset.

Reset
REQ-031 SHALL, on rst_n low at any time including mid-session, enter IDLE and clear the pipeline.
REQ-032 SHALL, on rst_n low, drive busy, done, fail, err_cnt, first_fail_addr and first_fail_mask to 0.

Configuration
REQ-033 SHALL, with BIST_FAIL_LOG_EN defined, add a 4-entry log of the first four failing addresses, read through input log_idx (2 bits) and outputs log_addr (ADDR_W) and log_cnt (3 bits, 0..4).
REQ-034 SHALL clear the log on start and reset, and ignore failures after the fourth.
REQ-035 SHALL, without BIST_FAIL_LOG_EN, omit the log ports and logic entirely.

Structure
REQ-036 SHALL import the state enum and the default width constants from the shared package bist_pkg.
REQ-037 SHALL instantiate one sub-module, bist_delay_line, a parameterized RD_LAT-deep register pipe for valid, addr and expected data.

Verification
REQ-038 SHALL pass the clean run: start, 32 reads of 0xA5 matching, last at addr 31 -> done at last+2, fail=0, err_cnt=0.
REQ-039 SHALL pass the single fault: rd_data 0xA4 at addr 7, exp 0xA5 -> fail=1, err_cnt=1, first_fail_addr=7, first_fail_mask=0x01.
REQ-040 SHALL pass the multi-fault: faults at addr 3 and 9 -> err_cnt=2, first_fail_addr=3 retained.
REQ-041 SHALL pass saturation: with ERR_CNT_W=2, 5 mismatches -> err_cnt=3, no wrap.
REQ-042 SHALL pass restart: start mid-CHECK after 1 fault -> results clear; clean rest -> fail=0; rd_en during DONE ignored.
REQ-043 SHALL pass async reset: rst_n low in DRAIN -> all outputs 0 immediately, IDLE; with RD_LAT=3, done at last+4.
